// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a word-wide synchronous RAM, sub-word stores by read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses with err; otherwise they are aligned down.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_ren,
  output logic        mem_wen,
  input  logic [31:0] mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_LDX  = 3'd2,
    S_MRG  = 3'd3,
    S_WR   = 3'd4
  } state_t;

  state_t      state_q;
  logic        is_store_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic        ren_q;
  logic        wen_q;

  // Address bits above the 4 KiB window never reach the memory.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:12];

  logic reject;
`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = ((size == 2'b10) && (addr[1:0] != 2'b00)) ||
                    ((size == 2'b01) && addr[0]);
  assign reject   = (size == 2'b11) || misalign;
`else
  assign reject   = (size == 2'b11);
`endif

  // Byte lanes touched by the latched request; addr[0] is ignored for halves.
  logic [3:0]  lane_en;
  logic [31:0] wdata_rep;
  always_comb begin
    lane_en   = 4'b1111;
    wdata_rep = wdata_q;
    case (size_q)
      2'b00: begin
        lane_en   = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_en   = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_en   = 4'b1111;
        wdata_rep = wdata_q;
      end
    endcase
  end

  // Lanes not addressed keep the old memory contents; a word store takes wdata wholesale.
  logic [31:0] merged;
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged[8*gi +: 8] = lane_en[gi] ? wdata_rep[8*gi +: 8] : mem_dout[8*gi +: 8];
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  always_comb begin
    ld_byte = mem_dout[7:0];
    case (addr_q[1:0])
      2'b00:   ld_byte = mem_dout[7:0];
      2'b01:   ld_byte = mem_dout[15:8];
      2'b10:   ld_byte = mem_dout[23:16];
      default: ld_byte = mem_dout[31:24];
    endcase
    ld_half = addr_q[1] ? mem_dout[31:16] : mem_dout[15:0];
    case (size_q)
      2'b00:   ld_val = {{24{~unsigned_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = {{16{~unsigned_q & ld_half[15]}}, ld_half};
      default: ld_val = mem_dout;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= 12'd0;
      wdata_q    <= 32'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'd0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      ren_q  <= 1'b0;
      wen_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            is_store_q <= is_store;
            size_q     <= size;
            unsigned_q <= unsigned_ld;
            addr_q     <= addr[11:0];
            wdata_q    <= wdata;
            if (reject) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else if (is_store && (size == 2'b10)) begin
              state_q <= S_WR;
              wen_q   <= 1'b1;
            end else begin
              state_q <= S_RD;
              ren_q   <= 1'b1;
            end
          end
        end
        S_RD: begin
          if (is_store_q) begin
            state_q <= S_MRG;
            wen_q   <= 1'b1;
          end else begin
            state_q <= S_LDX;
          end
        end
        S_LDX: begin
          rdata_q <= ld_val;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        S_MRG, S_WR: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign mem_addr = addr_q[11:2];
  assign mem_din  = merged;
  assign mem_ren  = ren_q;
  assign mem_wen  = wen_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expectations queued at issue, compared on each done pulse.
// Honours LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        unsigned_ld = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_dout;

  logic [31:0] mem [0:1023];

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          start_cyc;
    int          ren;
    int          wen;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          ren_cnt = 0;
  int          wen_cnt = 0;
  int          op_id = 0;
  logic [31:0] last_ld = 32'd0;

  load_store_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_store   (is_store),
    .size       (size),
    .unsigned_ld(unsigned_ld),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rdata      (rdata),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .mem_dout   (mem_dout)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one-cycle registered read.
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] <= mem_din;
    if (mem_ren) mem_dout <= mem[mem_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_ren) ren_cnt <= ren_cnt + 1;
    if (mem_wen) wen_cnt <= wen_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        $display("op %0d done rdata=%h err=%b", e.id, rdata, err);
        check($sformatf("op%0d_rdata", e.id), rdata, e.rdata);
        check($sformatf("op%0d_err", e.id), {31'b0, err}, {31'b0, e.err});
        check($sformatf("op%0d_latency", e.id), 32'(cyc - e.start_cyc), 32'(e.lat));
        check($sformatf("op%0d_ren_count", e.id), 32'(ren_cnt), 32'(e.ren));
        check($sformatf("op%0d_wen_count", e.id), 32'(wen_cnt), 32'(e.wen));
      end
    end
  end

  // Expected value of a load from word w at byte offset off.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] sh;
    sh = w >> (8 * off);
    if (sz == 2'b00) return uns ? (sh & 32'h0000_00FF) : 32'($signed(sh[7:0]));
    if (sz == 2'b01) return uns ? (sh & 32'h0000_FFFF) : 32'($signed(sh[15:0]));
    return w;
  endfunction

  // Called at a falling edge; returns at the falling edge of the done cycle.
  task automatic run_op(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_ld);
    exp_t e;
    logic mis;
    logic bad;
    bit   got;
    mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = ((sz == 2'b10) && (a[1:0] != 2'b00)) || ((sz == 2'b01) && a[0]);
`endif
    bad = (sz == 2'b11) || mis;
    e.id  = op_id;
    op_id++;
    e.err = bad;
    e.lat = bad ? 1 : ((st && sz == 2'b10) ? 2 : 3);
    e.ren = ren_cnt + ((bad || (st && sz == 2'b10)) ? 0 : 1);
    e.wen = wen_cnt + ((!bad && st) ? 1 : 0);
    if (!st && !bad) last_ld = exp_ld;
    e.rdata     = last_ld;
    e.start_cyc = cyc;
    sb_q.push_back(e);
    is_store = st; size = sz; unsigned_ld = uns; addr = a; wdata = wd; start = 1'b1;
    @(negedge clk);
    // A stray request while busy must be ignored; scrambled inputs check the latching.
    start = (e.lat > 1);
    is_store = 1'b1; size = 2'b00; addr = $urandom; wdata = $urandom;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      start = 1'b0;
    end
    if (!got) begin
      check("done_timeout", 32'd0, 32'd1);
      sb_q.delete();
    end
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] off;
    logic [1:0] sz;
    logic       uns;

    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ren", {31'b0, mem_ren}, 32'd0);
    check("rst_wen", {31'b0, mem_wen}, 32'd0);
    reset = 1'b0;

    run_op(1'b1, 2'b10, 1'b0, 32'h14, 32'h80FF7F01, 32'd0);
    check("mem5_sw", mem[5], 32'h80FF7F01);
    run_op(1'b0, 2'b00, 1'b0, 32'h15, 32'd0, 32'h0000007F);
    run_op(1'b0, 2'b00, 1'b0, 32'h16, 32'd0, 32'hFFFFFFFF);
    run_op(1'b0, 2'b00, 1'b1, 32'h16, 32'd0, 32'h000000FF);
    repeat (2) @(negedge clk);
    run_op(1'b0, 2'b01, 1'b0, 32'h16, 32'd0, 32'hFFFF80FF);
    run_op(1'b0, 2'b01, 1'b1, 32'h16, 32'd0, 32'h000080FF);
    run_op(1'b0, 2'b10, 1'b1, 32'h1014, 32'd0, 32'h80FF7F01);

    run_op(1'b1, 2'b00, 1'b0, 32'h15, 32'h123456AA, 32'd0);
    check("mem5_sb", mem[5], 32'h80FFAA01);
    run_op(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000BEEF, 32'd0);
    check("mem5_sh", mem[5], 32'hBEEFAA01);

    run_op(1'b0, 2'b10, 1'b0, 32'h16, 32'd0, 32'hBEEFAA01);
    run_op(1'b0, 2'b01, 1'b0, 32'h17, 32'd0, 32'hFFFFBEEF);
    run_op(1'b0, 2'b11, 1'b0, 32'h14, 32'd0, 32'd0);
    run_op(1'b1, 2'b11, 1'b0, 32'h14, 32'hFFFFFFFF, 32'd0);
    check("mem5_illegal", mem[5], 32'hBEEFAA01);

    for (int k = 0; k < 12; k++) begin
      if (k < 8) begin
        sz = 2'b00; off = 2'(k); uns = (k >= 4);
      end else begin
        sz = 2'b01; off = {k[0], 1'b0}; uns = k[1];
      end
      run_op(1'b0, sz, uns, 32'h14 + 32'(off), 32'd0, ref_load(mem[5], off, sz, uns));
    end

    @(negedge clk);
    run_op(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 32'd0);
    run_op(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 32'hDEADBEEF);
    run_op(1'b1, 2'b00, 1'b0, 32'h23, 32'h00000011, 32'd0);
    run_op(1'b1, 2'b00, 1'b0, 32'h20, 32'h00000022, 32'd0);
    check("mem8_sb", mem[8], 32'h11ADBE22);

    // Abort a byte store while it sits in the merge cycle.
    @(negedge clk);
    is_store = 1'b1; size = 2'b00; unsigned_ld = 1'b0; addr = 32'h21; wdata = 32'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_wen_in_mrg", {31'b0, mem_wen}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    check("abort_wen", {31'b0, mem_wen}, 32'd0);
    last_ld = 32'd0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("inrst_ren", {31'b0, mem_ren}, 32'd0);
      check("inrst_wen", {31'b0, mem_wen}, 32'd0);
    end
    reset = 1'b0;
    run_op(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 32'h11ADBE22);
    check("mem8_after_abort", mem[8], 32'h11ADBE22);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
